// File: rtl/fir_out_serializer.sv
// Buffers fir output samples in a small FIFO and streams each as OUT_W-bit beats, MSB slice first.
// Define FIR_SER_PARITY_EN to append an even-parity beat to every frame.
module fir_out_serializer #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              ser_ready,
    output logic [OUT_W-1:0]  ser_data,
    output logic              ser_valid,
    output logic              ser_sof,
    output logic              ser_eof,
    output logic              overflow
);
    localparam int BEATS = DATA_W / OUT_W;
    localparam int AW    = $clog2(DEPTH);
`ifdef FIR_SER_PARITY_EN
    localparam int FRAME = BEATS + 1;
    localparam int SH_W  = DATA_W + OUT_W;
`else
    localparam int FRAME = BEATS;
    localparam int SH_W  = DATA_W;
`endif
    localparam int CW = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW:0]        wr_ptr_reg, rd_ptr_reg, count;
    logic               full, empty, wr_en, pop;
    logic [DATA_W-1:0]  head;
    logic [SH_W-1:0]    shreg_reg, shreg_next, load_val;
    logic [CW-1:0]      beat_cnt_reg, beat_cnt_next;
    logic               valid_next, sof_next, eof_next;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count = wr_ptr_reg - rd_ptr_reg;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = in_valid && !full;
    assign head  = mem[rd_ptr_reg[AW-1:0]];

`ifdef FIR_SER_PARITY_EN
    // Parity beat rides in the low slice so the normal shift delivers it last.
    assign load_val = {head, OUT_W'(^head)};
`else
    assign load_val = head;
`endif

    assign ser_data = shreg_reg[SH_W-1 -: OUT_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= in_data;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        beat_cnt_next = beat_cnt_reg;
        valid_next    = ser_valid;
        sof_next      = ser_sof;
        eof_next      = ser_eof;
        pop           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_valid && ser_ready) begin
                    if (beat_cnt_reg == LAST) begin
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_next = IDLE;
                            valid_next = 1'b0;
                            sof_next   = 1'b0;
                            eof_next   = 1'b0;
                        end
                    end else begin
                        shreg_next    = shreg_reg << OUT_W;
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                        sof_next      = 1'b0;
                        eof_next      = (beat_cnt_next == LAST);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (pop) begin
            shreg_next    = load_val;
            beat_cnt_next = '0;
            valid_next    = 1'b1;
            sof_next      = 1'b1;
            eof_next      = (LAST == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            shreg_reg    <= '0;
            beat_cnt_reg <= '0;
            ser_valid    <= 1'b0;
            ser_sof      <= 1'b0;
            ser_eof      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shreg_reg    <= shreg_next;
            beat_cnt_reg <= beat_cnt_next;
            ser_valid    <= valid_next;
            ser_sof      <= sof_next;
            ser_eof      <= eof_next;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_out_serializer.sv
// Testbench for fir_out_serializer: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_fir_out_serializer;
    localparam int DATA_W = 32;
    localparam int OUT_W  = 4;
    localparam int DEPTH  = 4;
    localparam int BEATS  = DATA_W / OUT_W;
`ifdef FIR_SER_PARITY_EN
    localparam int FRAME = BEATS + 1;
`else
    localparam int FRAME = BEATS;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              ser_ready = 1'b0;
    logic [OUT_W-1:0]  ser_data;
    logic              ser_valid, ser_sof, ser_eof, overflow;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fir_out_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .ser_ready(ser_ready), .ser_data(ser_data), .ser_valid(ser_valid),
        .ser_sof(ser_sof), .ser_eof(ser_eof), .overflow(overflow)
    );

    // Reference model: a queue of buffered samples and a queue of beats left in the current frame.
    logic [DATA_W-1:0] m_fifo[$];
    logic [OUT_W-1:0]  m_frame[$];
    int                m_idx = 0;
    bit                m_ovf = 1'b0;

    function automatic void m_load(input logic [DATA_W-1:0] s);
        m_frame.delete();
        for (int b = 0; b < BEATS; b++)
            m_frame.push_back(OUT_W'(s >> (DATA_W - OUT_W * (b + 1))));
`ifdef FIR_SER_PARITY_EN
        m_frame.push_back(OUT_W'(^s));
`endif
        m_idx = 0;
    endfunction

    always @(posedge clk or posedge rst) begin : mdl
        int pre;
        if (rst) begin
            m_fifo.delete();
            m_frame.delete();
            m_idx = 0;
            m_ovf = 1'b0;
        end else begin
            pre = m_fifo.size();
            if (m_frame.size() > 0 && ser_ready) begin
                void'(m_frame.pop_front());
                m_idx++;
            end
            if (m_frame.size() == 0 && m_fifo.size() > 0)
                m_load(m_fifo.pop_front());
            if (in_valid) begin
                if (pre < DEPTH) m_fifo.push_back(in_data);
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0; ser_ready = 1'b0; rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({ser_data, ser_valid, ser_sof, ser_eof, overflow} !== '0)
            $display("FAIL reset_outputs got data=%h v=%b sof=%b eof=%b ovf=%b expected all 0",
                     ser_data, ser_valid, ser_sof, ser_eof, overflow);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ser_valid !== 1'b0) $display("FAIL reset_idle got valid=%b expected 0", ser_valid);
        else passed++;
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic exp_v;
        logic [OUT_W-1:0] exp_d;
        do_reset();
        ser_ready = 1'b1; in_valid = 1'b1; in_data = 32'h12345678;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= FRAME + 2; k++) begin
            exp_v = (k >= 2 && k <= FRAME + 1);
            exp_d = (k - 1 <= BEATS) ? OUT_W'(k - 1) : 4'd1;
            total++;
            if (ser_valid !== exp_v) $display("FAIL single_valid cycle %0d got %b expected %b", k, ser_valid, exp_v);
            else passed++;
            if (exp_v) begin
                total++;
                if ({ser_data, ser_sof, ser_eof} !== {exp_d, k == 2, k == FRAME + 1})
                    $display("FAIL single_beat cycle %0d got data=%h sof=%b eof=%b expected data=%h sof=%b eof=%b",
                             k, ser_data, ser_sof, ser_eof, exp_d, k == 2, k == FRAME + 1);
                else passed++;
            end
            @(negedge clk);
        end
        $display("test_single done");
    endtask

    task automatic test_stall();
        int i;
        logic exp_v;
        logic [OUT_W-1:0] exp_d;
        do_reset();
        ser_ready = 1'b1; in_valid = 1'b1; in_data = 32'h12345678;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= FRAME + 5; k++) begin
            ser_ready = !(k >= 3 && k <= 5);
            i = (k <= 2) ? k - 2 : (k <= 6) ? 1 : k - 5;
            exp_v = (k >= 2 && i < FRAME);
            exp_d = (i < BEATS) ? OUT_W'(i + 1) : 4'd1;
            total++;
            if (ser_valid !== exp_v) $display("FAIL stall_valid cycle %0d got %b expected %b", k, ser_valid, exp_v);
            else passed++;
            if (exp_v) begin
                total++;
                if ({ser_data, ser_sof, ser_eof} !== {exp_d, i == 0, i == FRAME - 1})
                    $display("FAIL stall_beat cycle %0d got data=%h sof=%b eof=%b expected data=%h sof=%b eof=%b",
                             k, ser_data, ser_sof, ser_eof, exp_d, i == 0, i == FRAME - 1);
                else passed++;
            end
            @(negedge clk);
        end
        ser_ready = 1'b1;
        $display("test_stall done");
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] s;
        logic [OUT_W-1:0] exp_d;
        int i;
        do_reset();
        ser_ready = 1'b1; in_valid = 1'b1; in_data = 32'hAAAAAAAA;
        @(negedge clk);
        in_data = 32'h0000FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j <= 2 * FRAME; j++) begin
            total++;
            if (ser_valid !== (j < 2 * FRAME))
                $display("FAIL b2b_valid beat %0d got %b expected %b", j, ser_valid, j < 2 * FRAME);
            else passed++;
            if (j < 2 * FRAME) begin
                s = (j < FRAME) ? 32'hAAAAAAAA : 32'h0000FFFF;
                i = j % FRAME;
                exp_d = (i < BEATS) ? OUT_W'(s >> (DATA_W - OUT_W * (i + 1))) : OUT_W'(^s);
                total++;
                if ({ser_data, ser_sof, ser_eof} !== {exp_d, i == 0, i == FRAME - 1})
                    $display("FAIL b2b_beat beat %0d got data=%h sof=%b eof=%b expected data=%h sof=%b eof=%b",
                             j, ser_data, ser_sof, ser_eof, exp_d, i == 0, i == FRAME - 1);
                else passed++;
            end
            @(negedge clk);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] got[$];
        logic [DATA_W-1:0] acc;
        int nb;
        do_reset();
        ser_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (overflow !== 1'b1) $display("FAIL ovf_set got %b expected 1", overflow);
        else passed++;
        total++;
        if ({ser_valid, ser_sof, ser_data} !== {1'b1, 1'b1, 4'h0})
            $display("FAIL ovf_hold got v=%b sof=%b data=%h expected v=1 sof=1 data=0", ser_valid, ser_sof, ser_data);
        else passed++;
        ser_ready = 1'b1;
        acc = '0; nb = 0;
        for (int c = 0; c < 100; c++) begin
            if (ser_valid) begin
                if (ser_sof) begin acc = '0; nb = 0; end
                if (nb < BEATS) acc = (acc << OUT_W) | DATA_W'(ser_data);
                nb++;
                if (ser_eof) got.push_back(acc);
            end
            @(negedge clk);
        end
        total++;
        if (got.size() != 5) $display("FAIL ovf_frames got %0d expected 5", got.size());
        else passed++;
        for (int i = 0; i < got.size() && i < 5; i++) begin
            total++;
            if (got[i] !== DATA_W'(i + 1)) $display("FAIL ovf_sample %0d got %h expected %h", i, got[i], i + 1);
            else passed++;
        end
        total++;
        if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b expected 1", overflow);
        else passed++;
        $display("test_overflow done");
    endtask

    // Runs right after test_overflow so overflow is still set going in.
    task automatic test_reset_midframe();
        ser_ready = 1'b1; in_valid = 1'b1; in_data = 32'h12345678;
        @(negedge clk);
        in_data = 32'hCAFEF00D;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        total++;
        if (ser_data !== 4'h4) $display("FAIL rstmid_beat3 got %h expected 4", ser_data);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({ser_valid, ser_sof, ser_eof, overflow, ser_data} !== '0)
            $display("FAIL rstmid_clear got v=%b sof=%b eof=%b ovf=%b data=%h expected all 0",
                     ser_valid, ser_sof, ser_eof, overflow, ser_data);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++;
            if (ser_valid !== 1'b0) $display("FAIL rstmid_quiet cycle %0d got valid=%b expected 0", c, ser_valid);
            else passed++;
        end
        $display("test_reset_midframe done");
    endtask

    task automatic test_parity_frame();
        logic [DATA_W-1:0] s;
        logic [OUT_W-1:0]  exp_par;
        for (int t = 0; t < 2; t++) begin
            s = (t == 0) ? 32'h00000007 : 32'h00000003;
            exp_par = (t == 0) ? 4'd1 : 4'd0;
            do_reset();
            ser_ready = 1'b1; in_valid = 1'b1; in_data = s;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            for (int i = 0; i <= FRAME; i++) begin
                total++;
                if (i == FRAME) begin
                    if (ser_valid !== 1'b0) $display("FAIL par_end sample %h got valid=%b expected 0", s, ser_valid);
                    else passed++;
                end else if (i < BEATS) begin
                    if ({ser_valid, ser_data, ser_eof} !== {1'b1, (i == BEATS - 1) ? s[3:0] : 4'h0, i == FRAME - 1})
                        $display("FAIL par_data sample %h beat %0d got v=%b data=%h eof=%b", s, i, ser_valid, ser_data, ser_eof);
                    else passed++;
                end else begin
                    if ({ser_valid, ser_data, ser_eof} !== {1'b1, exp_par, 1'b1})
                        $display("FAIL par_beat sample %h got v=%b data=%h eof=%b expected v=1 data=%h eof=1",
                                 s, ser_valid, ser_data, ser_eof, exp_par);
                    else passed++;
                end
                @(negedge clk);
            end
        end
        $display("test_parity_frame done");
    endtask

    task automatic test_random(input int n);
        logic exp_v;
        do_reset();
        for (int c = 0; c < n; c++) begin
            in_valid  = ($urandom_range(0, 99) < ((c < n / 2) ? 8 : 25));
            in_data   = $urandom;
            ser_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_v = (m_frame.size() > 0);
            total++;
            if ({ser_valid, overflow} !== {exp_v, m_ovf})
                $display("FAIL rand_ctrl cycle %0d got v=%b ovf=%b expected v=%b ovf=%b", c, ser_valid, overflow, exp_v, m_ovf);
            else passed++;
            if (exp_v) begin
                total++;
                if ({ser_data, ser_sof, ser_eof} !== {m_frame[0], m_idx == 0, m_frame.size() == 1})
                    $display("FAIL rand_beat cycle %0d got data=%h sof=%b eof=%b expected data=%h sof=%b eof=%b",
                             c, ser_data, ser_sof, ser_eof, m_frame[0], m_idx == 0, m_frame.size() == 1);
                else passed++;
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_parity_frame();
        test_random(4000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
